// File: rtl/ray_hit_collector_pkg.sv
// Shared fixed-point geometry types and FSM encoding for the ray hit collector.
// Values are Q16.16 signed; T_MAX marks "no hit yet".
package rt_pkg;

  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] fixed_t;
  typedef fixed_t [0:2]       vec3_t;
  typedef vec3_t [0:2]        tri_t;
  typedef vec3_t [0:1]        ray_t;

  localparam fixed_t T_MAX = 32'sh7FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ray_hit_collector_if.sv
// Bundle of job control, triangle memory and intersection-unit signals around
// the ray hit collector; slave is the collector side, master the environment.
interface ray_hit_collector_if
  import rt_pkg::*;
#(
  parameter int IDX_W = 8
) ();

  logic             i_start;
  ray_t             i_ray;
  logic [IDX_W-1:0] i_num_tri;
  logic             o_busy;

  logic             o_tri_rd;
  logic [IDX_W-1:0] o_tri_addr;
  tri_t             i_tri;

  logic             o_isect_en;
  tri_t             o_isect_tri;
  ray_t             o_isect_ray;
  logic             i_isect_valid;
  logic             i_isect_result;
  fixed_t           i_isect_t;

  logic             o_done;
  logic             o_hit;
  logic [IDX_W-1:0] o_hit_idx;
  fixed_t           o_hit_t;

  modport slave (
    input  i_start, i_ray, i_num_tri, i_tri, i_isect_valid, i_isect_result, i_isect_t,
    output o_busy, o_tri_rd, o_tri_addr, o_isect_en, o_isect_tri, o_isect_ray,
           o_done, o_hit, o_hit_idx, o_hit_t
  );

  modport master (
    output i_start, i_ray, i_num_tri, i_tri, i_isect_valid, i_isect_result, i_isect_t,
    input  o_busy, o_tri_rd, o_tri_addr, o_isect_en, o_isect_tri, o_isect_ray,
           o_done, o_hit, o_hit_idx, o_hit_t
  );

endinterface

// File: rtl/ray_hit_collector_hit_min_tracker.sv
// Keeps the closest hit seen so far; a strictly smaller signed t wins, so on a
// tie the earlier (lower) index is retained because responses arrive in order.
module hit_min_tracker
  import rt_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             upd,
  input  logic [IDX_W-1:0] upd_idx,
  input  fixed_t           upd_t,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output fixed_t           hit_t
);

  logic take;

  always_comb begin
    take = upd && (!hit || (upd_t < hit_t));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit     <= 1'b0;
      hit_idx <= '0;
      hit_t   <= T_MAX;
    end else if (clear) begin
      hit     <= 1'b0;
      hit_idx <= '0;
      hit_t   <= T_MAX;
    end else if (take) begin
      hit     <= 1'b1;
      hit_idx <= upd_idx;
      hit_t   <= upd_t;
    end
  end

endmodule

// File: rtl/ray_hit_collector.sv
// Streams triangles from memory to an intersection unit and collects the closest hit.
// Define RAY_HIT_COLLECTOR_ANY_HIT_EN to stop at the first reported hit instead.
module ray_hit_collector
  import rt_pkg::*;
#(
  parameter int IDX_W           = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  ray_hit_collector_if.slave bus
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0] IDX_ONE = 1;
  localparam logic [OUT_W-1:0] OUT_ONE = 1;
  localparam logic [OUT_W:0]   MAX_CNT = MAX_OUTSTANDING[OUT_W:0];

  state_t           state, state_nxt;
  ray_t             ray_q;
  logic [IDX_W-1:0] num_tri_q;
  logic [IDX_W-1:0] issued;
  logic [IDX_W-1:0] returned;
  logic [OUT_W-1:0] outstanding;
  logic             vld_p1;
  logic             done_q;

  logic start_ok, rsp_ok, take_rsp, room, rd, last_rd, stop_fetch, drain_done;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  fixed_t           hit_t;

`ifdef RAY_HIT_COLLECTOR_ANY_HIT_EN
  logic found, first_hit;
`endif

  always_comb begin
    start_ok = (state == ST_IDLE) && bus.i_start;
    rsp_ok   = bus.i_isect_valid && ((state == ST_FETCH) || (state == ST_DRAIN));
    // A read issued last cycle becomes a request this cycle, so it already occupies a slot
    room     = ({1'b0, outstanding} + {{OUT_W{1'b0}}, vld_p1}) < MAX_CNT;
`ifdef RAY_HIT_COLLECTOR_ANY_HIT_EN
    first_hit  = rsp_ok && bus.i_isect_result && !found;
    take_rsp   = first_hit;
    stop_fetch = found || first_hit;
    drain_done = found ? ((outstanding == '0) && !vld_p1) : (returned == num_tri_q);
`else
    take_rsp   = rsp_ok && bus.i_isect_result;
    stop_fetch = 1'b0;
    drain_done = (returned == num_tri_q);
`endif
    rd      = (state == ST_FETCH) && (issued < num_tri_q) && room && !stop_fetch;
    last_rd = rd && (issued == (num_tri_q - IDX_ONE));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = (bus.i_num_tri == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (last_rd || stop_fetch) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: read strobe becomes the intersection request one cycle later
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_IDLE;
      num_tri_q   <= '0;
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
      vld_p1      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= rd;
      done_q <= (state == ST_DONE);
      if (start_ok) begin
        num_tri_q <= bus.i_num_tri;
        issued    <= '0;
        returned  <= '0;
      end else begin
        if (rd)     issued   <= issued + IDX_ONE;
        if (rsp_ok) returned <= returned + IDX_ONE;
      end
      case ({vld_p1, rsp_ok})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef RAY_HIT_COLLECTOR_ANY_HIT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)        found <= 1'b0;
    else if (start_ok)  found <= 1'b0;
    else if (first_hit) found <= 1'b1;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (start_ok) ray_q <= bus.i_ray;
  end

  hit_min_tracker #(
    .IDX_W (IDX_W)
  ) u_tracker (
    .clk     (i_clk),
    .rst_n   (i_rstn),
    .clear   (start_ok),
    .upd     (take_rsp),
    .upd_idx (returned),
    .upd_t   (bus.i_isect_t),
    .hit     (hit),
    .hit_idx (hit_idx),
    .hit_t   (hit_t)
  );

  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_tri_rd    = rd;
  assign bus.o_tri_addr  = issued;
  assign bus.o_isect_en  = vld_p1;
  assign bus.o_isect_tri = bus.i_tri;
  assign bus.o_isect_ray = ray_q;
  assign bus.o_done      = done_q;
  assign bus.o_hit       = hit;
  assign bus.o_hit_idx   = hit_idx;
  assign bus.o_hit_t     = hit_t;

endmodule

// File: tb/tb_ray_hit_collector.sv
// Directed bench for ray_hit_collector with a triangle memory and an in-order
// intersection-unit model of configurable latency.
module tb_ray_hit_collector;
  import rt_pkg::*;

  localparam int IDX_W = 8;
  localparam int MAXO  = 16;

  typedef struct {
    int     due;
    logic   hit;
    fixed_t t;
  } rsp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ray_hit_collector_if #(.IDX_W(IDX_W)) bus ();

  ray_hit_collector #(
    .IDX_W           (IDX_W),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  tri_t   mem     [0:63];
  logic   res_hit [0:63];
  fixed_t res_t   [0:63];
  rsp_t   q[$];
  int     lat = 2, cyc = 0, req_k = 0, rsp_k = 0;
  int     out_cnt = 0, out_max = 0, done_cnt = 0;
  int     last_rd_cyc = 0, rsp1_cyc = 0;
  logic [IDX_W-1:0] addr_q = '0;
  ray_t   ray_cur;

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tri_t mk_tri(input int ax, input int ay, input int az,
                                  input int bx, input int by, input int bz,
                                  input int cx, input int cy, input int cz);
    tri_t t;
    t[0][0] = ax; t[0][1] = ay; t[0][2] = az;
    t[1][0] = bx; t[1][1] = by; t[1][2] = bz;
    t[2][0] = cx; t[2][1] = cy; t[2][2] = cz;
    return t;
  endfunction

  // Triangle memory: data for the address read in the previous cycle
  always @(posedge clk) begin
    #1;
    bus.i_tri = mem[addr_q];
  end

  // Intersection-unit model and observation counters
  always @(negedge clk) begin
    rsp_t r;
    cyc++;
    if (bus.o_tri_rd) begin
      addr_q      = bus.o_tri_addr;
      last_rd_cyc = cyc;
    end
    if (bus.o_done) done_cnt++;
    bus.i_isect_valid  = 1'b0;
    bus.i_isect_result = 1'b0;
    bus.i_isect_t      = '0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      r = q.pop_front();
      bus.i_isect_valid  = 1'b1;
      bus.i_isect_result = r.hit;
      bus.i_isect_t      = r.t;
      if (rsp_k == 1) rsp1_cyc = cyc;
      rsp_k++;
      out_cnt--;
    end
    if (bus.o_isect_en) begin
      check("isect_tri", bus.o_isect_tri, mem[req_k]);
      check("isect_ray", bus.o_isect_ray, ray_cur);
      r.due = cyc + lat;
      r.hit = res_hit[req_k];
      r.t   = res_t[req_k];
      q.push_back(r);
      req_k++;
      out_cnt++;
      if (out_cnt > out_max) out_max = out_cnt;
    end
  end

  task automatic clear_tables();
    for (int i = 0; i < 64; i++) begin
      mem[i]     = mk_tri(i * 65536, i, 0, 0, i + 1, 0, 0, 0, 7);
      res_hit[i] = 1'b0;
      res_t[i]   = '0;
    end
  endtask

  task automatic load_basic();
    clear_tables();
    mem[0] = mk_tri(-65536, -65536, 0, 65536, -65536, 0, 0, 65536, 0);
    mem[1] = mk_tri(327680, 327680, 0, 393216, 327680, 0, 327680, 393216, 0);
    mem[2] = mk_tri(-65536, -65536, 32768, 65536, -65536, 32768, 0, 65536, 32768);
    res_hit[0] = 1'b1; res_t[0] = 32'sd65536;
    res_hit[2] = 1'b1; res_t[2] = 32'sd32768;
  endtask

  task automatic start_job(input int n, input int latency);
    lat      = latency;
    req_k    = 0;
    rsp_k    = 0;
    out_cnt  = 0;
    out_max  = 0;
    done_cnt = 0;
    @(negedge clk);
    bus.i_ray     = ray_cur;
    bus.i_num_tri = IDX_W'(n);
    bus.i_start   = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic run_job(input string tag, input int n, input int latency,
                         input logic exp_hit, input int exp_idx, input fixed_t exp_t);
    logic got;
    start_job(n, latency);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, got, 1'b1);
    check({tag, "_hit"}, bus.o_hit, exp_hit);
    check({tag, "_idx"}, bus.o_hit_idx, IDX_W'(exp_idx));
    check({tag, "_t"}, bus.o_hit_t, exp_t);
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle"}, bus.o_busy, 1'b0);
    check({tag, "_t_hold"}, bus.o_hit_t, exp_t);
  endtask

  initial begin
    bus.i_start   = 1'b0;
    bus.i_num_tri = '0;
    ray_cur       = '0;
    ray_cur[0][2] = 32'sd65536;
    ray_cur[1][2] = -32'sd65536;
    bus.i_ray     = ray_cur;
    clear_tables();

    repeat (3) @(negedge clk);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_tri_rd", bus.o_tri_rd, 1'b0);
    check("rst_tri_addr", bus.o_tri_addr, '0);
    check("rst_isect_en", bus.o_isect_en, 1'b0);
    check("rst_done", bus.o_done, 1'b0);
    check("rst_hit", bus.o_hit, 1'b0);
    check("rst_hit_idx", bus.o_hit_idx, '0);
    check("rst_hit_t", bus.o_hit_t, T_MAX);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Empty job: done two cycles after the start pulse, no hit
    start_job(0, 2);
    check("zero_done_early", bus.o_done, 1'b0);
    @(negedge clk);
    check("zero_done", bus.o_done, 1'b1);
    check("zero_hit", bus.o_hit, 1'b0);
    check("zero_idx", bus.o_hit_idx, '0);
    check("zero_t", bus.o_hit_t, T_MAX);
    @(negedge clk);
    check("zero_done_pulse", bus.o_done, 1'b0);

`ifndef RAY_HIT_COLLECTOR_ANY_HIT_EN
    load_basic();
    run_job("basic", 3, 3, 1'b1, 2, 32'sd32768);

    clear_tables();
    mem[0] = mk_tri(-65536, -65536, 0, 65536, -65536, 0, 0, 65536, 0);
    mem[1] = mk_tri(-131072, -65536, 0, 65536, -131072, 0, 0, 131072, 0);
    res_hit[0] = 1'b1; res_t[0] = 32'sd65536;
    res_hit[1] = 1'b1; res_t[1] = 32'sd65536;
    run_job("tie", 2, 2, 1'b1, 0, 32'sd65536);

    clear_tables();
    res_hit[5]  = 1'b1; res_t[5]  = 32'sd300000;
    res_hit[17] = 1'b1; res_t[17] = 32'sd100000;
    res_hit[22] = 1'b1; res_t[22] = 32'sd200000;
    res_hit[30] = 1'b1; res_t[30] = 32'sd100000;
    res_hit[39] = 1'b1; res_t[39] = -32'sd5;
    run_job("deep", 40, 20, 1'b1, 39, -32'sd5);
    check("deep_out_le_max", (out_max <= MAXO), 1'b1);
    check("deep_out_reach", out_max, MAXO);
`else
    clear_tables();
    res_hit[1] = 1'b1; res_t[1] = 32'sd5000;
    res_hit[2] = 1'b1; res_t[2] = 32'sd100;
    run_job("anyhit", 20, 3, 1'b1, 1, 32'sd5000);
    check("anyhit_rd_stop", (last_rd_cyc <= rsp1_cyc + 2), 1'b1);
    check("anyhit_no_tail", (req_k < 20), 1'b1);
`endif

    // Abort a job during drain; late responses must not disturb the idle block
    clear_tables();
    res_hit[3] = 1'b1; res_t[3] = 32'sd1000;
    start_job(10, 20);
    repeat (15) @(negedge clk);
    check("abort_busy", bus.o_busy, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_rst_busy", bus.o_busy, 1'b0);
    check("abort_rst_rd", bus.o_tri_rd, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    check("abort_q_empty", q.size(), 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_hit", bus.o_hit, 1'b0);
    check("abort_t", bus.o_hit_t, T_MAX);

    load_basic();
`ifndef RAY_HIT_COLLECTOR_ANY_HIT_EN
    run_job("after_abort", 3, 2, 1'b1, 2, 32'sd32768);
`else
    run_job("after_abort", 3, 2, 1'b1, 0, 32'sd65536);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ray_hit_collector.md
RAY_HIT_COLLECTOR -- requirements
Module: ray_hit_collector

Interface
REQ-001 SHALL have parameter IDX_W, default 8, width of triangle index and count.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16, maximum number of intersection requests in flight.
REQ-003 i_clk  input  1  sole clock, rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous and active-low.
REQ-005 i_start  input  1  one-cycle pulse that launches a ray job; ignored while o_busy=1.
REQ-006 i_ray  input  signed [31:0] [0:1][0:2]  ray; [0] is origin E, [1] is direction D; Q16.16.
REQ-007 i_num_tri  input  IDX_W  number of triangles to test, sampled on i_start.
REQ-008 o_busy  output  1  job in progress.
REQ-009 o_tri_rd / o_tri_addr  output  1 / IDX_W  triangle memory read strobe and address.
REQ-010 i_tri  input  signed [31:0] [0:2][0:2]  vertex data, valid exactly 1 cycle after o_tri_rd.
REQ-011 o_isect_en / o_isect_tri / o_isect_ray  output  1 / [0:2][0:2] / [0:1][0:2]  request to the intersection unit.
REQ-012 i_isect_valid / i_isect_result / i_isect_t  input  1 / 1 / signed 32  in-order response from the intersection unit; t is Q16.16.
REQ-013 o_done / o_hit / o_hit_idx / o_hit_t  output  1 / 1 / IDX_W / signed 32  job-complete pulse, hit flag, winning index, winning t.

Function
REQ-014 SHALL implement FSM IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
REQ-015 IDLE: i_start=1 latches i_ray and i_num_tri, clears hit state, and enters FETCH; if i_num_tri=0, SHALL enter DONE directly.
REQ-016 FETCH: SHALL assert o_tri_rd with incrementing o_tri_addr from 0 while issued<i_num_tri and outstanding<MAX_OUTSTANDING.
REQ-017 SHALL assert o_isect_en for exactly one cycle per triangle, in the cycle its data returns (1 cycle after o_tri_rd), with o_isect_tri=i_tri and o_isect_ray equal to the latched ray.
REQ-018 SHALL sustain one request per cycle; the outstanding counter SHALL increment on o_isect_en, decrement on i_isect_valid, and stay unchanged when both occur in the same cycle.
REQ-019 Response index SHALL equal a return counter that increments per i_isect_valid, because responses are in order.
REQ-020 On i_isect_valid with i_isect_result=1, SHALL update the best hit when no hit is held or i_isect_t < best t (signed strict compare); ties keep the lower index.
REQ-021 FETCH -> DRAIN when the last read issues; DRAIN -> DONE when returned count equals i_num_tri.
REQ-022 DONE: SHALL pulse o_done for 1 cycle; o_hit/o_hit_idx/o_hit_t SHALL hold until the next accepted i_start.
REQ-023 With no hit, o_hit=0, o_hit_idx=0, o_hit_t=32'h7FFF_FFFF.
REQ-024 i_isect_valid in IDLE or DONE SHALL be ignored.

Reset
REQ-025 i_rstn=0 SHALL force IDLE and clear o_busy, o_tri_rd, o_tri_addr, o_isect_en, o_done, o_hit, o_hit_idx, and all counters; o_hit_t SHALL reset to 32'h7FFF_FFFF.
REQ-026 Reset mid-job SHALL abort with no o_done; responses still in flight after reset release SHALL be ignored per REQ-024.

Configuration
REQ-027 With macro RAY_HIT_COLLECTOR_ANY_HIT_EN defined: on the first i_isect_result=1, SHALL stop issuing reads, record that hit, go to DRAIN, and discard later responses; o_done SHALL pulse once outstanding reaches 0.
REQ-028 Without the macro, SHALL perform closest-hit search over all triangles as in REQ-020.

Structure
REQ-029 Package rt_pkg SHALL hold FRAC_BITS=16, fixed_t (signed 32), vec3_t, tri_t, ray_t, and T_MAX=32'h7FFF_FFFF.
REQ-030 Sub-module hit_min_tracker SHALL hold the compare/update of best t and index (REQ-020, REQ-023).

Verification
REQ-031 Ray E=(0,0,1), D=(0,0,-1); triangles: [0] plane z=0 (t=1 -> 65536), [1] miss, [2] plane z=0.5 (t=0.5 -> 32768); i_num_tri=3 -> o_hit=1, o_hit_idx=2, o_hit_t=32768.
REQ-032 i_num_tri=0 -> o_done pulses 2 cycles after i_start, with o_hit=0 and o_hit_t=32'h7FFF_FFFF.
REQ-033 Two triangles both giving t=65536 -> o_hit_idx=0.
REQ-034 i_num_tri=40 with model latency 20 -> outstanding never exceeds 16, o_done pulses once, and the winner matches the model.
REQ-035 Deassert i_rstn during DRAIN, then start a new job -> no o_done for the aborted job, and the new job's result is correct.
REQ-036 RAY_HIT_COLLECTOR_ANY_HIT_EN with hits at indices 1 and 2 -> o_hit_idx=1, and o_tri_rd stops within 2 cycles of the response for index 1.
